// File: rtl/lfsr_descrambler_pkg.sv
// Shared definitions for the LFSR descrambler: FSM states, LFSR geometry, feedback taps.
// Warm-up length default lives here; warm-up logic itself is built only with LFSR_WARMUP_EN.
package lfsr_descrambler_pkg;

   localparam int LFSR_W = 80;

   localparam int TAP_A = 62;
   localparam int TAP_B = 51;
   localparam int TAP_C = 38;
   localparam int TAP_D = 23;
   localparam int TAP_E = 13;
   localparam int TAP_F = 0;

   localparam int DEFAULT_WARMUP_CYCLES = 160;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_WARMUP = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   // Bit entering position LFSR_W-1 on each shift toward bit 0.
   function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] s);
      return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D] ^ s[TAP_E] ^ s[TAP_F];
   endfunction

endpackage

// File: rtl/lfsr_descrambler_keystream.sv
// 80-bit keystream generator: seed load, shift enable, keystream bit = current s[0].
module lfsr_keystream
   import lfsr_descrambler_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              shift,
   output logic              ks_bit
);

   logic [LFSR_W-1:0] s;

   // A load overrides any shift requested in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s <= '0;
      end else if (load) begin
         s <= seed;
      end else if (shift) begin
         s <= {lfsr_feedback(s), s[LFSR_W-1:1]};
      end
   end

   assign ks_bit = s[0];

endmodule

// File: rtl/lfsr_descrambler.sv
// Serial-in LFSR descrambler with byte packer and output backpressure.
// Optional warm-up phase (discarded keystream after seed load) enabled by macro LFSR_WARMUP_EN.
module lfsr_descrambler
   import lfsr_descrambler_pkg::*;
#(
   parameter int WARMUP_CYCLES = DEFAULT_WARMUP_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              in_valid,
   input  logic              in_bit,
   output logic              in_ready,
   output logic              out_valid,
   output logic [7:0]        out_data,
   input  logic              out_ready,
   output logic              busy,
   output state_t            dbg_state
);

   state_t     state;
   state_t     next_state;
   logic [2:0] bit_cnt;
   logic [7:0] partial;
   logic       ks_bit;
   logic       accept;
   logic       shift;
   logic       plain_bit;

   // Handshakes: a transfer happens on a cycle where valid & ready are both high at the rising
   // edge; valid never depends on ready, and out_valid/out_data hold until out_ready accepts.
   assign in_ready  = (state == ST_RUN) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign plain_bit = in_bit ^ ks_bit;
   assign busy      = (state == ST_LOAD) || (state == ST_WARMUP);
   assign dbg_state = state;

`ifdef LFSR_WARMUP_EN
   localparam int WCW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

   logic [WCW-1:0] warm_cnt;
   logic           warm_done;

   assign warm_done = (warm_cnt == WCW'(WARMUP_CYCLES - 1));
   assign shift     = (state == ST_WARMUP) || accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         warm_cnt <= '0;
      end else if (load || (state != ST_WARMUP)) begin
         warm_cnt <= '0;
      end else begin
         warm_cnt <= warm_cnt + WCW'(1);
      end
   end
`else
   localparam int unused_warmup_cycles = WARMUP_CYCLES;

   assign shift = accept;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   next_state = ST_IDLE;
`ifdef LFSR_WARMUP_EN
         ST_LOAD:   next_state = (WARMUP_CYCLES > 0) ? ST_WARMUP : ST_RUN;
         ST_WARMUP: next_state = warm_done ? ST_RUN : ST_WARMUP;
`else
         ST_LOAD:   next_state = ST_RUN;
         ST_WARMUP: next_state = ST_RUN;
`endif
         ST_RUN:    next_state = ST_RUN;
         default:   next_state = ST_IDLE;
      endcase
      if (load) begin
         next_state = ST_LOAD;
      end
   end

   lfsr_keystream u_keystream (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .seed   (seed),
      .shift  (shift),
      .ks_bit (ks_bit)
   );

   // The completing bit writes out_valid last, so a byte finishing in the same cycle the held
   // byte is taken replaces it without a bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bit_cnt   <= '0;
         partial   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         bit_cnt   <= '0;
         partial   <= '0;
         out_valid <= 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            partial[bit_cnt] <= plain_bit;
            bit_cnt          <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               out_data  <= {plain_bit, partial[6:0]};
               out_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_descrambler.sv
// Bench for lfsr_descrambler: random and directed bit streams against a keystream-sequence
// model, expected bytes queued at issue time and popped by an output monitor.
module tb_lfsr_descrambler;
   import lfsr_descrambler_pkg::*;

`ifdef LFSR_WARMUP_EN
   localparam int WARM = DEFAULT_WARMUP_CYCLES;
`else
   localparam int WARM = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load = 1'b0;
   logic [79:0] seed = '0;
   logic        in_valid = 1'b0;
   logic        in_bit = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready = 1'b1;
   logic        busy;
   state_t      dbg_state;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  exp_q[$];
   bit          ks_q[$];
   int          ks_pos = 0;
   int          ready_mode = 0;

   lfsr_descrambler #(.WARMUP_CYCLES(DEFAULT_WARMUP_CYCLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .seed      (seed),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Keystream as a sequence: k[i] = seed[i] for i < 80, and each later bit is the XOR of the
   // bits 0,13,23,38,51,62 positions after the start of its 80-bit window.
   function automatic bit ks_at(input int n);
      while (ks_q.size() <= n) begin
         int b;
         b = ks_q.size() - 80;
         ks_q.push_back(ks_q[b+62] ^ ks_q[b+51] ^ ks_q[b+38] ^ ks_q[b+23] ^ ks_q[b+13] ^ ks_q[b]);
      end
      return ks_q[n];
   endfunction

   function automatic void model_restart(input logic [79:0] s);
      ks_q.delete();
      for (int i = 0; i < 80; i++) ks_q.push_back(s[i]);
      ks_pos = WARM;
   endfunction

   function automatic logic [7:0] xor_ks(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[i] ^ ks_at(ks_pos + i);
      return r;
   endfunction

   function automatic logic [79:0] rand_seed();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[79:0];
   endfunction

   // ---------------- driver tasks ----------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
         endcase
      end
   end

   task automatic send_bit(input logic b);
      bit done;
      done = 0;
      in_valid = 1'b1;
      in_bit   = b;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (done) begin
         ks_pos++;
      end else begin
         checks++;
         errors++;
         $display("FAIL send_bit_timeout: in_ready got 0 required 1");
      end
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] c, input logic [7:0] e);
      exp_q.push_back(e);
      for (int i = 0; i < 8; i++) send_bit(c[i]);
   endtask

   task automatic send_random_byte();
      logic [7:0] pt;
      pt = 8'($urandom_range(0, 255));
      send_byte(xor_ks(pt), pt);
   endtask

   // LOAD is one busy cycle, WARMUP adds WARM more; in_ready must stay low throughout.
   task automatic do_load(input logic [79:0] s);
      int n_busy;
      int n_warm;
      bit bad_ready;
      bit reached;
      n_busy = 0;
      n_warm = 0;
      bad_ready = 0;
      reached = 0;
      seed = s;
      load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      model_restart(s);
      for (int i = 0; i < WARM + 20 && !reached; i++) begin
         @(negedge clk);
         if (dbg_state == ST_RUN) begin
            reached = 1;
         end else begin
            if (busy) n_busy++;
            if (dbg_state == ST_WARMUP) n_warm++;
            if (in_ready) bad_ready = 1;
         end
      end
      check("reach_run", 80'(reached), 80'(1));
      check("busy_cycles", 80'(n_busy), 80'(1 + WARM));
      check("warmup_cycles", 80'(n_warm), 80'(WARM));
      check("in_ready_while_busy", 80'(bad_ready), 80'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      bit empty;
      empty = 0;
      for (int i = 0; i < 300 && !empty; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) empty = 1;
      end
      check("drain", 80'(exp_q.size()), 80'(0));
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin : monitor
      logic [7:0] e;
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h required no byte", out_data);
         end else begin
            e = exp_q.pop_front();
            check("byte", 80'(out_data), 80'(e));
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin : main
      logic [7:0] c;
      logic [7:0] e;
      logic [7:0] pt;
      logic [7:0] held;
      bit         bad;
      bit         got;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 80'(in_ready), 80'(0));
      check("rst_out_valid", 80'(out_valid), 80'(0));
      check("rst_out_data", 80'(out_data), 80'(0));
      check("rst_busy", 80'(busy), 80'(0));
      check("rst_state", 80'(dbg_state), 80'(ST_IDLE));
      rst = 1'b1;
      @(posedge clk);
      #1;

      in_valid = 1'b1;
      in_bit   = 1'b1;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (in_ready || out_valid || dbg_state != ST_IDLE) bad = 1;
      end
      check("idle_ignores_in_valid", 80'(bad), 80'(0));
      @(posedge clk);
      #1;
      in_valid = 1'b0;

      // Zero seed: keystream is all zero, so ciphertext passes through.
      do_load(80'h0);
      c = 8'hA5;
`ifdef LFSR_WARMUP_EN
      e = xor_ks(c);
`else
      e = 8'hA5;
`endif
      send_byte(c, e);
      wait_drain();

      // Seed 1: first eight keystream bits are seed[7:0].
      do_load(80'h1);
`ifdef LFSR_WARMUP_EN
      e = xor_ks(8'h00);
`else
      e = 8'h01;
`endif
      send_byte(8'h00, e);
      send_byte(8'h00, xor_ks(8'h00));
      wait_drain();

      ready_mode = 1;
      do_load(rand_seed());
      repeat (20) send_random_byte();
      ready_mode = 0;
      wait_drain();

      // Hold the output: input must stall and the byte must not change.
      ready_mode = 2;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      pt = 8'($urandom_range(0, 255));
      send_byte(xor_ks(pt), pt);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (out_valid) got = 1;
      end
      check("bp_out_valid", 80'(got), 80'(1));
      held = out_data;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (in_ready || !out_valid || out_data !== held) bad = 1;
      end
      check("bp_hold", 80'(bad), 80'(0));
      ready_mode = 0;
      @(negedge clk);
      check("bp_in_ready_on_accept", 80'(in_ready), 80'(1));
      @(negedge clk);
      check("bp_released_in_ready", 80'(in_ready), 80'(1));
      check("bp_released_out_valid", 80'(out_valid), 80'(0));
      @(posedge clk);
      #1;

      // Reset part-way through a byte.
      for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_in_ready", 80'(in_ready), 80'(0));
      check("midrst_out_valid", 80'(out_valid), 80'(0));
      check("midrst_out_data", 80'(out_data), 80'(0));
      check("midrst_busy", 80'(busy), 80'(0));
      check("midrst_state", 80'(dbg_state), 80'(ST_IDLE));
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("idle_after_reset", 80'(dbg_state), 80'(ST_IDLE));
      do_load(rand_seed());
      repeat (3) send_random_byte();
      wait_drain();

      // Reload after three bits: partial byte dropped, next byte starts at bit 0.
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
      do_load(rand_seed());
      ready_mode = 1;
      repeat (4) send_random_byte();
      ready_mode = 0;
      wait_drain();

      check("exp_q_empty", 80'(exp_q.size()), 80'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
